// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter merging NUM_REQ requesters into one FIFO write port.
// Define FIFO_ARB_BURST_EN to lock the winner for up to BURST_LEN consecutive beats.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    wr_idx,
    output logic                          arb_lock
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  fifo_wr_en_q, fifo_wr_en_d;
    logic [DATA_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;

    logic                  accept_ok;
    logic                  rr_hit;
    logic [IDX_W-1:0]      rr_win;
    logic                  win_valid;
    logic [IDX_W-1:0]      win_idx;

    // A registered write still in flight counts against an almost-full FIFO.
    assign accept_ok = !fifo_full && !(fifo_wr_en_q && fifo_almost_full);

    // Scan from the farthest candidate down so the nearest one after rr_ptr wins.
    always_comb begin
        int cand;
        cand   = 0;
        rr_hit = 1'b0;
        rr_win = rr_ptr_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (req[cand]) begin
                rr_hit = 1'b1;
                rr_win = IDX_W'(cand);
            end
        end
    end

`ifdef FIFO_ARB_BURST_EN
    // state | meaning
    // IDLE  | per-beat round-robin arbitration
    // LOCK  | burst owner (== rr_ptr) holds the port until BURST_LEN beats or it drops req
    typedef enum logic {IDLE, LOCK} state_t;

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = rr_win;
        state_d   = state_q;
        beat_d    = beat_q;
        if (rst_n && accept_ok) begin
            if (state_q == LOCK) begin
                win_idx = rr_ptr_q;
                if (req[rr_ptr_q]) begin
                    win_valid = 1'b1;
                    if (beat_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                    beat_d  = '0;
                end
            end else if (rr_hit) begin
                win_valid = 1'b1;
                if (BURST_LEN > 1) begin
                    state_d = LOCK;
                    beat_d  = CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    assign arb_lock = (state_q == LOCK);
`else
    always_comb begin
        win_valid = rst_n && accept_ok && rr_hit;
        win_idx   = rr_win;
    end

    assign arb_lock = 1'b0;
`endif

    always_comb begin
        gnt = '0;
        if (win_valid) begin
            gnt = NUM_REQ'(1) << win_idx;
        end
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        fifo_wr_en_d   = 1'b0;
        fifo_data_in_d = fifo_data_in_q;
        wr_idx_d       = wr_idx_q;
        if (win_valid) begin
            rr_ptr_d       = win_idx;
            fifo_wr_en_d   = 1'b1;
            fifo_data_in_d = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            wr_idx_d       = win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= IDX_W'(NUM_REQ - 1);
            fifo_wr_en_q   <= 1'b0;
            fifo_data_in_q <= '0;
            wr_idx_q       <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_data_in_q <= fifo_data_in_d;
            wr_idx_q       <= wr_idx_d;
        end
    end

    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_data_in = fifo_data_in_q;
    assign wr_idx       = wr_idx_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-free behavioural arbitration model plus directed literal checks.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int BL = 4;
`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic                 clk;
    logic                 rst_n;
    logic [NR-1:0]        req;
    logic [NR*DW-1:0]     req_data;
    logic [NR-1:0]        gnt;
    logic                 fifo_full;
    logic                 fifo_almost_full;
    logic                 fifo_wr_en;
    logic [DW-1:0]        fifo_data_in;
    logic [1:0]           wr_idx;
    logic                 arb_lock;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
        .wr_idx(wr_idx), .arb_lock(arb_lock)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: which requester should win, and what the FIFO should see next cycle.
    int            m_rr;
    bit            m_lock;
    int            m_beats;
    logic          m_wr_en;
    logic [DW-1:0] m_data;
    int            m_idx;
    logic          m_ok;
    logic [NR-1:0] m_gnt;

    function automatic logic [NR-1:0] model_gnt(input logic [NR-1:0] r, input logic ok,
                                                 input int rr, input bit lk);
        if (!ok) return '0;
        if (lk) return r[rr] ? (NR'(1) << rr) : '0;
        for (int k = 1; k <= NR; k++)
            if (r[(rr + k) % NR]) return NR'(1) << ((rr + k) % NR);
        return '0;
    endfunction

    always_comb begin
        m_ok  = !fifo_full && !(m_wr_en && fifo_almost_full);
        m_gnt = rst_n ? model_gnt(req, m_ok, m_rr, m_lock) : '0;
    end

    always @(posedge clk or negedge rst_n) begin
        int w;
        w = 0;
        if (!rst_n) begin
            m_rr <= NR - 1; m_lock <= 1'b0; m_beats <= 0;
            m_wr_en <= 1'b0; m_data <= '0; m_idx <= 0;
        end else if (m_gnt != '0) begin
            for (int i = 0; i < NR; i++) if (m_gnt[i]) w = i;
            m_wr_en <= 1'b1;
            m_data  <= req_data[w*DW +: DW];
            m_idx   <= w;
            m_rr    <= w;
            if (BURST_ON) begin
                if (!m_lock) begin
                    if (BL > 1) begin m_lock <= 1'b1; m_beats <= 1; end
                end else if (m_beats + 1 == BL) begin
                    m_lock <= 1'b0; m_beats <= 0;
                end else begin
                    m_beats <= m_beats + 1;
                end
            end
        end else begin
            m_wr_en <= 1'b0;
            if (m_lock && m_ok && !req[m_rr]) begin m_lock <= 1'b0; m_beats <= 0; end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_gnt", 32'(gnt), 32'(m_gnt));
            chk("model_wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
            chk("model_data", 32'(fifo_data_in), 32'(m_data));
            chk("model_idx", 32'(wr_idx), 32'(m_idx));
            chk("model_lock", 32'(arb_lock), 32'(m_lock));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [NR-1:0] exp_a [9];

    initial begin
`ifdef FIFO_ARB_BURST_EN
        exp_a = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
`else
        exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(8'hA0 + i);
        req = 4'b1111;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("rst_lock", 32'(arb_lock), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        // Continuous requests from everyone.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("seq_gnt", 32'(gnt), 32'(exp_a[i]));
            tick();
            if (i == 0) begin
                chk("first_wr_en", 32'(fifo_wr_en), 32'h1);
                chk("first_idx", 32'(wr_idx), 32'h0);
                chk("first_data", 32'(fifo_data_in), 32'hA0);
            end
        end
        req = 4'b0000;
        tick();
        tick();

        // Full FIFO holds off two requesters for three cycles.
        do_reset();
        req = 4'b0101;
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_gnt", 32'(gnt), 32'h0);
            chk("full_wr_en", 32'(fifo_wr_en), 32'h0);
            tick();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        chk("full_rel_gnt0", 32'(gnt), 32'b0001);
        tick();
        @(negedge clk);
        if (BURST_ON) chk("full_rel_gnt1", 32'(gnt), 32'b0001);
        else          chk("full_rel_gnt1", 32'(gnt), 32'b0100);
        tick();

        // Almost-full while a write is in flight, then full.
        req = 4'b1111;
        fifo_almost_full = 1'b1;
        @(negedge clk);
        chk("af_wr_en", 32'(fifo_wr_en), 32'h1);
        chk("af_gnt", 32'(gnt), 32'h0);
        tick();
        fifo_almost_full = 1'b0;
        fifo_full = 1'b1;
        @(negedge clk);
        chk("af_full_gnt", 32'(gnt), 32'h0);
        chk("af_full_wr_en", 32'(fifo_wr_en), 32'h0);
        tick();
        fifo_full = 1'b0;
        repeat (3) tick();

        // Owner drops its request after two beats.
        do_reset();
        req = 4'b1111;
        tick();
        tick();
        req = 4'b1110;
        @(negedge clk);
        if (BURST_ON) begin
            chk("drop_gnt", 32'(gnt), 32'h0);
            chk("drop_lock", 32'(arb_lock), 32'h1);
        end
        tick();
        @(negedge clk);
        if (BURST_ON) begin
            chk("drop_next_gnt", 32'(gnt), 32'b0010);
            chk("drop_next_lock", 32'(arb_lock), 32'h0);
        end
        tick();
        tick();

        // Reset pulse in the middle of a burst.
        do_reset();
        req = 4'b1111;
        tick();
        @(negedge clk);
        chk("mid_lock_pre", 32'(arb_lock), BURST_ON ? 32'h1 : 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_lock", 32'(arb_lock), 32'h0);
        chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_gnt", 32'(gnt), 32'b0001);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of write requesters, 2..8.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: FIFO word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 4: maximum beats per locked burst, 1..16; used only with FIFO_ARB_BURST_EN.
REQ-004 The block SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req  input  NUM_REQ  per-requester write request.
REQ-007 The block SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  requester i word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port gnt  output  NUM_REQ  one-hot accept; transfer occurs at the posedge where gnt[i]=1.
REQ-009 The block SHALL have port fifo_full  input  1  FIFO full flag.
REQ-010 The block SHALL have port fifo_almost_full  input  1  FIFO holds DEPTH-1 words.
REQ-011 The block SHALL have port fifo_wr_en  output  1  registered FIFO write enable.
REQ-012 The block SHALL have port fifo_data_in  output  DATA_WIDTH  registered FIFO write data.
REQ-013 The block SHALL have port wr_idx  output  clog2(NUM_REQ)  source index of fifo_data_in, valid while fifo_wr_en=1.
REQ-014 The block SHALL have port arb_lock  output  1  burst lock active.

Function
REQ-015 The block SHALL define accept_ok = !fifo_full && !(fifo_wr_en && fifo_almost_full).
REQ-016 The block SHALL drive gnt combinationally from req, accept_ok and internal state; at most one bit set; gnt=0 when accept_ok=0 or req=0.
REQ-017 Round-robin: the winner SHALL be the first set req bit after rr_ptr, searched modulo NUM_REQ; rr_ptr SHALL update to the winner index on transfer only.
REQ-018 On a transfer, the block SHALL register fifo_wr_en=1, fifo_data_in=req_data[winner] and wr_idx=winner at that posedge (latency 1 cycle); with no transfer, fifo_wr_en SHALL be 0 and fifo_data_in/wr_idx SHALL hold.
REQ-019 Requesters hold req and data until granted; the block SHALL accept req deasserted without a grant, with no state change.
REQ-020 Backpressure (accept_ok=0): the block SHALL freeze rr_ptr, FSM state and beat counter, and SHALL NOT drop or duplicate a word.
REQ-021 Sustained writes: with accept_ok=1 the block SHALL grant one word every cycle (full throughput).

Reset
REQ-022 rst_n low SHALL immediately force fifo_wr_en=0, fifo_data_in=0, wr_idx=0, arb_lock=0, gnt=0, rr_ptr=NUM_REQ-1, state=IDLE and beat count=0.
REQ-023 Reset mid-operation SHALL abandon any burst; a registered write not yet seen by the FIFO SHALL be dropped. rst_n deassertion is synchronised externally to clk.
REQ-024 The first grant after reset with all req set SHALL go to requester 0.

Configuration
REQ-025 The macro FIFO_ARB_BURST_EN, when defined, SHALL add FSM IDLE/LOCK: IDLE -> LOCK on a transfer when BURST_LEN>1 (owner=winner, count=1); in LOCK only the owner SHALL be granted, each transfer increments count, and the FSM SHALL return to IDLE after the BURST_LEN-th beat; arb_lock=1 in LOCK.
REQ-026 In LOCK with req[owner]=0, the block SHALL return to IDLE at that posedge with no grant that cycle; arbitration resumes next cycle from rr_ptr=owner.
REQ-027 Without FIFO_ARB_BURST_EN, the block SHALL have no FSM or counter, SHALL perform per-beat round-robin and SHALL tie arb_lock to 0; the port list SHALL be identical.

Verification
REQ-028 Reset: rst_n=0, req=4'b1111 -> gnt=0, fifo_wr_en=0; after release, gnt=4'b0001, then fifo_wr_en=1 with wr_idx=0 one cycle later.
REQ-029 Macro off, req=4'b1111, FIFO empty -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; wr_idx 0,1,2,3,0; fifo_data_in matches each source.
REQ-030 fifo_full=1 for 3 cycles, req=4'b0101 -> gnt=0 and no writes; on release -> gnt 0001, then 0100.
REQ-031 fifo_almost_full=1 while fifo_wr_en=1 -> gnt=0 that cycle; next cycle with fifo_full=1 -> still 0, so the FIFO never overflows (count never exceeds DEPTH).
REQ-032 Macro on, BURST_LEN=4, req=4'b1111 -> gnt 0001 x4, then 0010 x4, arb_lock=1 during each burst; req[0] dropped after 2 beats -> arb_lock=0, one idle cycle, next gnt=0010.
REQ-033 Macro on, rst_n pulsed low during beat 2 of a burst -> arb_lock=0, fifo_wr_en=0 at once; after release, first gnt=0001.
